// File: rtl/axi4_mgr_sched.sv
// Round-robin scheduler that shares one axi4_mgr between NUM_REQ clients.
// The write and read channels each run their own IDLE->ISSUE->BUSY->DONE sequencer.
module axi4_mgr_sched #(
  parameter int NUM_REQ          = 4,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int DATA_COUNT_WIDTH = 8
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic [NUM_REQ-1:0]                  wr_req_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [NUM_REQ*DATA_COUNT_WIDTH-1:0] wr_count_i,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   wr_data_i,
  output logic [NUM_REQ-1:0]                  wr_gnt_o,
  output logic [NUM_REQ-1:0]                  wr_done_o,
  output logic [1:0]                          wr_err_o,
  input  logic [NUM_REQ-1:0]                  rd_req_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   rd_addr_i,
  input  logic [NUM_REQ*DATA_COUNT_WIDTH-1:0] rd_count_i,
  output logic [NUM_REQ-1:0]                  rd_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]           rd_data_o,
  output logic [NUM_REQ-1:0]                  rd_done_o,
  output logic [1:0]                          rd_err_o,
  output logic [1:0]                          mgr_req_o,
  output logic [AXI_ADDR_WIDTH-1:0]           mgr_wr_addr_o,
  output logic [AXI_ADDR_WIDTH-1:0]           mgr_rd_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]           mgr_data_o,
  output logic [DATA_COUNT_WIDTH-1:0]         mgr_wr_count_o,
  output logic [DATA_COUNT_WIDTH-1:0]         mgr_rd_count_o,
  input  logic [1:0]                          mgr_rsp_i,
  input  logic [1:0]                          mgr_wr_err_i,
  input  logic [1:0]                          mgr_rd_err_i,
  input  logic [AXI_DATA_WIDTH-1:0]           mgr_data_i
);
  localparam int N   = NUM_REQ;
  localparam int AW  = AXI_ADDR_WIDTH;
  localparam int DW  = AXI_DATA_WIDTH;
  localparam int CW  = DATA_COUNT_WIDTH;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int CNW = CW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_e;

  // Channel 0 is write, channel 1 is read; per-client buses viewed as packed arrays.
  logic [1:0][N-1:0]         ch_req;
  logic [1:0][N-1:0][AW-1:0] ch_addr_in;
  logic [1:0][N-1:0][CW-1:0] ch_count_in;
  logic [1:0][1:0]           ch_err_in;
  logic [1:0]                ch_issue;
  logic [1:0][AW-1:0]        ch_addr;
  logic [1:0][CW-1:0]        ch_count;
  logic [1:0][N-1:0]         ch_gnt;
  logic [1:0][N-1:0]         ch_done;
  logic [1:0][1:0]           ch_err;
  logic [N-1:0][DW-1:0]      wr_data_arr;
  logic                      rd_beat;

  assign ch_req      = {rd_req_i, wr_req_i};
  assign ch_addr_in  = {rd_addr_i, wr_addr_i};
  assign ch_count_in = {rd_count_i, wr_count_i};
  assign ch_err_in   = {mgr_rd_err_i, mgr_wr_err_i};
  assign wr_data_arr = wr_data_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    state_e         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d, idx_q, idx_d, sel, cand;
    logic [AW-1:0]  addr_q, addr_d, addr_out;
    logic [CW-1:0]  count_q, count_d, count_out;
    logic [CNW-1:0] cnt_q, cnt_d, exp_cnt;
    logic           pend_q, pend_d, pow2, sample_en, issue;
    logic [1:0]     err_q, err_d, err_out;
    logic [N-1:0]   idx_oh, gnt_out, done_out;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        state_q <= IDLE;
        ptr_q   <= '0;
        idx_q   <= '0;
        addr_q  <= '0;
        count_q <= '0;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        err_q   <= 2'b00;
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        idx_q   <= idx_d;
        addr_q  <= addr_d;
        count_q <= count_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        err_q   <= err_d;
      end
    end

    // Scan offsets from the far end so the requester closest to ptr_q wins.
    always_comb begin
      sel  = ptr_q;
      cand = ptr_q;
      for (int k = N - 1; k >= 0; k--) begin
        cand = IW'((int'(ptr_q) + k) % N);
        if (ch_req[gi][cand]) sel = cand;
      end
    end

    // Power-of-two writes go out as one burst (one B); reads carry one extra trailing R beat.
    assign pow2      = (count_q != '0) && ((count_q & (count_q - 1'b1)) == '0);
    assign sample_en = (gi == 0) || !(pow2 && (cnt_q < {1'b0, count_q}));
    assign exp_cnt   = (gi == 1) ? {1'b0, count_q} + 1'b1
                                 : (pow2 ? CNW'(1) : {1'b0, count_q});
    assign idx_oh    = N'(1) << idx_q;

    always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      count_d = count_q;
      cnt_d   = cnt_q;
      pend_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
        IDLE: begin
          if (|ch_req[gi]) begin
            idx_d   = sel;
            ptr_d   = (sel == IW'(N - 1)) ? '0 : sel + 1'b1;
            addr_d  = ch_addr_in[gi][sel];
            count_d = ch_count_in[gi][sel];
            cnt_d   = '0;
            err_d   = 2'b00;
            state_d = (ch_count_in[gi][sel] == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: state_d = BUSY;
        BUSY: begin
          if (mgr_rsp_i[gi]) begin
            cnt_d  = cnt_q + 1'b1;
            pend_d = 1'b1;
          end
          if (pend_q) begin
            if (sample_en) err_d = ch_err_in[gi];
            if ((sample_en && (ch_err_in[gi] != 2'b00)) || (cnt_q == exp_cnt)) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      issue     = 1'b0;
      addr_out  = '0;
      count_out = '0;
      gnt_out   = '0;
      done_out  = '0;
      err_out   = 2'b00;
      if (state_q != IDLE) begin
        addr_out  = addr_q;
        count_out = count_q;
        gnt_out   = idx_oh;
      end
      if (state_q == ISSUE) issue = 1'b1;
      if (state_q == DONE) begin
        done_out = idx_oh;
        err_out  = err_q;
      end
    end

    assign ch_issue[gi] = issue;
    assign ch_addr[gi]  = addr_out;
    assign ch_count[gi] = count_out;
    assign ch_gnt[gi]   = gnt_out;
    assign ch_done[gi]  = done_out;
    assign ch_err[gi]   = err_out;

    // Beats 1..count are forwarded; the trailing beat count+1 is swallowed.
    if (gi == 1) begin : g_rd
      assign rd_beat = (state_q == BUSY) && pend_q && (cnt_q <= {1'b0, count_q});
    end
  end

  always_comb begin
    mgr_data_o = '0;
    for (int i = 0; i < N; i++) begin
      if (ch_gnt[0][i]) mgr_data_o = wr_data_arr[i];
    end
  end

  assign mgr_req_o      = ch_issue;
  assign mgr_wr_addr_o  = ch_addr[0];
  assign mgr_rd_addr_o  = ch_addr[1];
  assign mgr_wr_count_o = ch_count[0];
  assign mgr_rd_count_o = ch_count[1];
  assign wr_gnt_o       = ch_gnt[0];
  assign wr_done_o      = ch_done[0];
  assign wr_err_o       = ch_err[0];
  assign rd_done_o      = ch_done[1];
  assign rd_err_o       = ch_err[1];
  assign rd_valid_o     = rd_beat ? ch_gnt[1] : '0;
  assign rd_data_o      = rd_beat ? mgr_data_i : '0;
endmodule

// File: tb/tb_axi4_mgr_sched.sv
// Directed bench for axi4_mgr_sched; the bench plays the axi4_mgr side by hand,
// pulsing rsp and presenting registered err/data one cycle later.
module tb_axi4_mgr_sched;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int CW = 8;

  logic            clk_i = 1'b0;
  logic            rstn_i = 1'b0;
  logic [N-1:0]    wr_req_i = '0;
  logic [N*AW-1:0] wr_addr_i = '0;
  logic [N*CW-1:0] wr_count_i = '0;
  logic [N*DW-1:0] wr_data_i = '0;
  logic [N-1:0]    wr_gnt_o, wr_done_o;
  logic [1:0]      wr_err_o;
  logic [N-1:0]    rd_req_i = '0;
  logic [N*AW-1:0] rd_addr_i = '0;
  logic [N*CW-1:0] rd_count_i = '0;
  logic [N-1:0]    rd_valid_o, rd_done_o;
  logic [DW-1:0]   rd_data_o;
  logic [1:0]      rd_err_o;
  logic [1:0]      mgr_req_o;
  logic [AW-1:0]   mgr_wr_addr_o, mgr_rd_addr_o;
  logic [DW-1:0]   mgr_data_o;
  logic [CW-1:0]   mgr_wr_count_o, mgr_rd_count_o;
  logic [1:0]      mgr_rsp_i = '0;
  logic [1:0]      mgr_wr_err_i = '0;
  logic [1:0]      mgr_rd_err_i = '0;
  logic [DW-1:0]   mgr_data_i = '0;

  int n_chk  = 0;
  int n_pass = 0;

  axi4_mgr_sched #(
    .NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .DATA_COUNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_count_i(wr_count_i), .wr_data_i(wr_data_i),
    .wr_gnt_o(wr_gnt_o), .wr_done_o(wr_done_o), .wr_err_o(wr_err_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_count_i(rd_count_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_done_o(rd_done_o), .rd_err_o(rd_err_o),
    .mgr_req_o(mgr_req_o), .mgr_wr_addr_o(mgr_wr_addr_o), .mgr_rd_addr_o(mgr_rd_addr_o),
    .mgr_data_o(mgr_data_o), .mgr_wr_count_o(mgr_wr_count_o), .mgr_rd_count_o(mgr_rd_count_o),
    .mgr_rsp_i(mgr_rsp_i), .mgr_wr_err_i(mgr_wr_err_i), .mgr_rd_err_i(mgr_rd_err_i),
    .mgr_data_i(mgr_data_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic b_pulse(input logic [1:0] err);
    mgr_rsp_i[0] = 1'b1;
    tick();
    mgr_rsp_i[0] = 1'b0;
    mgr_wr_err_i = err;
    #1;
  endtask

  task automatic r_pulse(input logic [1:0] err, input logic [DW-1:0] d);
    mgr_rsp_i[1] = 1'b1;
    tick();
    mgr_rsp_i[1] = 1'b0;
    mgr_rd_err_i = err;
    mgr_data_i   = d;
    #1;
  endtask

  task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [CW-1:0] n,
                        input logic [DW-1:0] d);
    wr_addr_i[c*AW +: AW]  = a;
    wr_count_i[c*CW +: CW] = n;
    wr_data_i[c*DW +: DW]  = d;
  endtask

  task automatic set_rd(input int c, input logic [AW-1:0] a, input logic [CW-1:0] n);
    rd_addr_i[c*AW +: AW]  = a;
    rd_count_i[c*CW +: CW] = n;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    wr_req_i = 4'b1111;
    rd_req_i = 4'b1111;
    mgr_data_i = 64'hFFFF_0000_FFFF_0000;
    tick();
    tick();
    n_chk++; if (wr_gnt_o !== 4'b0000) $display("FAIL rst_wr_gnt: got %b want 0000", wr_gnt_o); else n_pass++;
    n_chk++; if (mgr_req_o !== 2'b00) $display("FAIL rst_mgr_req: got %b want 00", mgr_req_o); else n_pass++;
    n_chk++; if (mgr_wr_addr_o !== '0 || mgr_rd_addr_o !== '0) $display("FAIL rst_addr: got %h/%h want 0/0", mgr_wr_addr_o, mgr_rd_addr_o); else n_pass++;
    n_chk++; if (rd_valid_o !== 4'b0000 || rd_data_o !== '0) $display("FAIL rst_rd_out: got %b/%h want 0000/0", rd_valid_o, rd_data_o); else n_pass++;
    n_chk++; if (wr_done_o !== '0 || rd_done_o !== '0 || mgr_data_o !== '0) $display("FAIL rst_done_data: got %b/%b/%h want 0/0/0", wr_done_o, rd_done_o, mgr_data_o); else n_pass++;
    wr_req_i = '0;
    rd_req_i = '0;
    mgr_data_i = '0;
    rstn_i = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_rr_fairness();
    logic [N-1:0] exp_g [4];
    exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    set_wr(0, 32'h10, 8'd1, 64'h0);
    set_wr(1, 32'h20, 8'd1, 64'h1);
    set_wr(3, 32'h30, 8'd1, 64'h3);
    wr_req_i = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (wr_gnt_o !== exp_g[i] || mgr_req_o[0] !== 1'b1) $display("FAIL rr_grant%0d: got gnt=%b req=%b want gnt=%b req=1", i, wr_gnt_o, mgr_req_o[0], exp_g[i]); else n_pass++;
      tick();
      b_pulse(2'b00);
      tick();
      n_chk++; if (wr_done_o !== exp_g[i]) $display("FAIL rr_done%0d: got %b want %b", i, wr_done_o, exp_g[i]); else n_pass++;
      $display("rr op %0d: gnt=%b done=%b", i, exp_g[i], wr_done_o);
      tick();
    end
    wr_req_i = '0;
    tick();
  endtask

  task automatic test_write_basic();
    set_wr(2, 32'h100, 8'd4, 64'hDEAD_BEEF_0000_0002);
    wr_req_i = 4'b0100;
    tick();
    n_chk++; if (mgr_req_o !== 2'b01 || mgr_wr_addr_o !== 32'h100) $display("FAIL wb_issue: got req=%b addr=%h want 01/100", mgr_req_o, mgr_wr_addr_o); else n_pass++;
    n_chk++; if (wr_gnt_o !== 4'b0100 || mgr_wr_count_o !== 8'd4) $display("FAIL wb_gnt_cnt: got %b/%0d want 0100/4", wr_gnt_o, mgr_wr_count_o); else n_pass++;
    n_chk++; if (mgr_data_o !== 64'hDEAD_BEEF_0000_0002) $display("FAIL wb_data: got %h want deadbeef00000002", mgr_data_o); else n_pass++;
    tick();
    n_chk++; if (mgr_req_o !== 2'b00 || mgr_wr_addr_o !== 32'h100) $display("FAIL wb_busy: got req=%b addr=%h want 00/100", mgr_req_o, mgr_wr_addr_o); else n_pass++;
    tick();
    b_pulse(2'b00);
    n_chk++; if (wr_done_o !== 4'b0000) $display("FAIL wb_early_done: got %b want 0000", wr_done_o); else n_pass++;
    tick();
    n_chk++; if (wr_done_o !== 4'b0100 || wr_err_o !== 2'b00) $display("FAIL wb_done: got %b/%b want 0100/00", wr_done_o, wr_err_o); else n_pass++;
    wr_req_i = '0;
    tick();
    n_chk++; if (wr_done_o !== '0 || wr_gnt_o !== '0 || mgr_wr_addr_o !== '0) $display("FAIL wb_idle: got %b/%b/%h want 0/0/0", wr_done_o, wr_gnt_o, mgr_wr_addr_o); else n_pass++;
    $display("write_basic: done pulse seen for client 2");
  endtask

  task automatic test_write_err();
    set_wr(0, 32'h200, 8'd3, 64'h5);
    wr_req_i = 4'b0001;
    tick();
    n_chk++; if (wr_gnt_o !== 4'b0001 || mgr_wr_count_o !== 8'd3) $display("FAIL we_gnt: got %b/%0d want 0001/3", wr_gnt_o, mgr_wr_count_o); else n_pass++;
    tick();
    b_pulse(2'b00);
    tick();
    n_chk++; if (wr_done_o !== 4'b0000) $display("FAIL we_after_b1: got %b want 0000", wr_done_o); else n_pass++;
    b_pulse(2'b10);
    tick();
    n_chk++; if (wr_done_o !== 4'b0001 || wr_err_o !== 2'b10) $display("FAIL we_done: got %b/%b want 0001/10", wr_done_o, wr_err_o); else n_pass++;
    set_wr(1, 32'h280, 8'd2, 64'h6);
    wr_req_i = 4'b0010;
    tick();
    tick();
    n_chk++; if (wr_gnt_o !== 4'b0010 || mgr_req_o !== 2'b01 || mgr_wr_addr_o !== 32'h280) $display("FAIL we_next_issue: got %b/%b/%h want 0010/01/280", wr_gnt_o, mgr_req_o, mgr_wr_addr_o); else n_pass++;
    tick();
    b_pulse(2'b00);
    tick();
    n_chk++; if (wr_done_o !== 4'b0010 || wr_err_o !== 2'b00) $display("FAIL we_next_done: got %b/%b want 0010/00", wr_done_o, wr_err_o); else n_pass++;
    wr_req_i = '0;
    tick();
    $display("write_err: errored op then normal op completed");
  endtask

  task automatic test_count_zero();
    set_wr(3, 32'h300, 8'd0, 64'h7);
    wr_req_i = 4'b1000;
    tick();
    n_chk++; if (mgr_req_o !== 2'b00 || wr_done_o !== 4'b1000 || wr_err_o !== 2'b00) $display("FAIL cz_done: got req=%b done=%b err=%b want 00/1000/00", mgr_req_o, wr_done_o, wr_err_o); else n_pass++;
    wr_req_i = '0;
    tick();
    n_chk++; if (wr_done_o !== 4'b0000 || mgr_req_o !== 2'b00) $display("FAIL cz_idle: got done=%b req=%b want 0000/00", wr_done_o, mgr_req_o); else n_pass++;
    $display("count_zero: skipped issue");
  endtask

  task automatic test_read_basic();
    logic [DW-1:0] d;
    set_rd(1, 32'h2000, 8'd3);
    rd_req_i = 4'b0010;
    tick();
    n_chk++; if (mgr_req_o !== 2'b10 || mgr_rd_addr_o !== 32'h2000 || mgr_rd_count_o !== 8'd3) $display("FAIL rb_issue: got %b/%h/%0d want 10/2000/3", mgr_req_o, mgr_rd_addr_o, mgr_rd_count_o); else n_pass++;
    tick();
    for (int k = 1; k <= 4; k++) begin
      d = 64'hD000 + 64'(k - 1);
      r_pulse(2'b00, d);
      if (k <= 3) begin
        n_chk++; if (rd_valid_o !== 4'b0010 || rd_data_o !== d) $display("FAIL rb_beat%0d: got %b/%h want 0010/%h", k, rd_valid_o, rd_data_o, d); else n_pass++;
      end else begin
        n_chk++; if (rd_valid_o !== 4'b0000 || rd_done_o !== 4'b0000) $display("FAIL rb_trailing: got %b/%b want 0000/0000", rd_valid_o, rd_done_o); else n_pass++;
      end
      $display("read_basic beat %0d: valid=%b data=%h", k, rd_valid_o, rd_data_o);
    end
    tick();
    n_chk++; if (rd_done_o !== 4'b0010 || rd_err_o !== 2'b00 || rd_valid_o !== 4'b0000) $display("FAIL rb_done: got %b/%b/%b want 0010/00/0000", rd_done_o, rd_err_o, rd_valid_o); else n_pass++;
    rd_req_i = '0;
    tick();
    n_chk++; if (rd_done_o !== 4'b0000) $display("FAIL rb_idle: got %b want 0000", rd_done_o); else n_pass++;
  endtask

  task automatic test_read_burst_after_err();
    logic [DW-1:0] d;
    set_rd(3, 32'h3000, 8'd1);
    rd_req_i = 4'b1000;
    tick();
    tick();
    r_pulse(2'b10, 64'hE1);
    n_chk++; if (rd_valid_o !== 4'b1000 || rd_data_o !== 64'hE1) $display("FAIL re_beat: got %b/%h want 1000/e1", rd_valid_o, rd_data_o); else n_pass++;
    tick();
    n_chk++; if (rd_done_o !== 4'b1000 || rd_err_o !== 2'b10) $display("FAIL re_done: got %b/%b want 1000/10", rd_done_o, rd_err_o); else n_pass++;
    set_rd(0, 32'h4000, 8'd4);
    rd_req_i = 4'b0001;
    tick();
    tick();
    n_chk++; if (mgr_req_o !== 2'b10 || mgr_rd_count_o !== 8'd4) $display("FAIL rbst_issue: got %b/%0d want 10/4", mgr_req_o, mgr_rd_count_o); else n_pass++;
    tick();
    for (int k = 1; k <= 5; k++) begin
      d = 64'hB000 + 64'(k);
      r_pulse((k <= 3) ? 2'b10 : 2'b00, d);
      n_chk++;
      if (k <= 4) begin
        if (rd_valid_o !== 4'b0001 || rd_data_o !== d || rd_done_o !== 4'b0000) $display("FAIL rbst_beat%0d: got %b/%h/%b want 0001/%h/0000", k, rd_valid_o, rd_data_o, rd_done_o, d); else n_pass++;
      end else begin
        if (rd_valid_o !== 4'b0000 || rd_done_o !== 4'b0000) $display("FAIL rbst_trailing: got %b/%b want 0000/0000", rd_valid_o, rd_done_o); else n_pass++;
      end
    end
    tick();
    n_chk++; if (rd_done_o !== 4'b0001 || rd_err_o !== 2'b00) $display("FAIL rbst_done: got %b/%b want 0001/00", rd_done_o, rd_err_o); else n_pass++;
    rd_req_i = '0;
    mgr_rd_err_i = 2'b00;
    tick();
    $display("read_burst: stale error ignored on burst beats");
  endtask

  task automatic test_reset_mid_op();
    set_wr(2, 32'h500, 8'd5, 64'hCAFE);
    set_wr(3, 32'h600, 8'd1, 64'hBEEF);
    wr_req_i = 4'b0100;
    tick();
    tick();
    b_pulse(2'b00);
    tick();
    n_chk++; if (wr_gnt_o !== 4'b0100) $display("FAIL rm_busy_gnt: got %b want 0100", wr_gnt_o); else n_pass++;
    rstn_i = 1'b0;
    #1;
    n_chk++; if (wr_gnt_o !== '0 || mgr_wr_addr_o !== '0 || mgr_data_o !== '0 || mgr_wr_count_o !== '0) $display("FAIL rm_async: got %b/%h/%h/%0d want 0/0/0/0", wr_gnt_o, mgr_wr_addr_o, mgr_data_o, mgr_wr_count_o); else n_pass++;
    wr_req_i = 4'b1100;
    set_wr(2, 32'h500, 8'd1, 64'hCAFE);
    tick();
    n_chk++; if (wr_done_o !== '0 || mgr_req_o !== '0 || wr_gnt_o !== '0) $display("FAIL rm_held: got %b/%b/%b want 0/0/0", wr_done_o, mgr_req_o, wr_gnt_o); else n_pass++;
    rstn_i = 1'b1;
    tick();
    n_chk++; if (wr_gnt_o !== 4'b0100 || mgr_wr_addr_o !== 32'h500 || mgr_req_o !== 2'b01) $display("FAIL rm_regrant: got %b/%h/%b want 0100/500/01", wr_gnt_o, mgr_wr_addr_o, mgr_req_o); else n_pass++;
    tick();
    b_pulse(2'b00);
    tick();
    n_chk++; if (wr_done_o !== 4'b0100) $display("FAIL rm_done: got %b want 0100", wr_done_o); else n_pass++;
    wr_req_i = '0;
    tick();
    $display("reset_mid_op: client 2 re-granted after reset");
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_write_basic();
    test_write_err();
    test_count_zero();
    test_read_basic();
    test_read_burst_after_err();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
